// File: rtl/membus_pkg.sv
// membus_arbiter shared definitions: owner states, I/O port address, counter sizing.
// Imported by membus_arbiter and membus_starve_ctr.
package membus_pkg;

  typedef logic [1:0] owner_t;

  localparam owner_t ST_CPU     = 2'd0;
  localparam owner_t ST_DMA     = 2'd1;
  localparam owner_t ST_RESTORE = 2'd2;

  localparam logic [15:0] IO_ADDR_DEF = 16'hBFFC;

  localparam int CTR_W_MIN = 1;

  function automatic int ctr_w(input int max_v);
    return (max_v < 1) ? CTR_W_MIN : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/membus_starve_ctr.sv
// Saturating wait counter for a pending DMA request.
// Ports: clk, reset (sync, high), inc, clr (wins over inc), at_max (count == MAX).
module membus_starve_ctr
  import membus_pkg::*;
#(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = ctr_w(MAX);
  localparam logic [W-1:0] TOP = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max = (cnt_q == TOP);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !at_max)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/membus_arbiter.sv
// Shares main memory between the cpu4510 core and one DMA requester.
// Ports: cpu_* (next-cycle bus, sync, ready, di), dma_* (req/gnt beat handshake,
// read return), mem_* (memory bus), io_cs (I/O port address decode).
// MEMBUS_BURST_EN defined: up to BURST_LEN beats per grant; otherwise one beat.
module membus_arbiter
  import membus_pkg::*;
#(
  parameter int          MAX_WAIT  = 8,
`ifdef MEMBUS_BURST_EN
  parameter int          BURST_LEN = 4,
`endif
  parameter logic [15:0] IO_ADDR   = IO_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr_next,
  input  logic        cpu_we_next,
  input  logic [7:0]  cpu_do_next,
  input  logic        cpu_sync,
  output logic        cpu_ready,
  output logic [7:0]  cpu_di,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [7:0]  dma_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_di,
  input  logic [7:0]  mem_do,
  output logic        io_cs
);

  owner_t state_q, state_d;
  logic   cpu_ready_q, cpu_ready_d;
  logic   dma_gnt_q, dma_gnt_d;
  logic   dma_rvalid_q, dma_rvalid_d;
  logic   grant, accept, at_max, we_raw;

`ifdef MEMBUS_BURST_EN
  localparam int BEAT_W = ctr_w(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_TOP = BEAT_W'(BURST_LEN);
  logic [BEAT_W-1:0] beat_q, beat_d, beat_inc;
  assign beat_inc = beat_q + 1'b1;
`endif

  assign accept = dma_gnt_q & dma_req;

  membus_starve_ctr #(
    .MAX (MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    ((state_q == ST_CPU) & dma_req & ~grant),
    .clr    (~dma_req | grant | (state_q != ST_CPU)),
    .at_max (at_max)
  );

  always_comb begin
    state_d      = state_q;
    cpu_ready_d  = cpu_ready_q;
    dma_gnt_d    = dma_gnt_q;
    dma_rvalid_d = 1'b0;
    grant        = 1'b0;
`ifdef MEMBUS_BURST_EN
    beat_d       = beat_q;
`endif
    unique case (state_q)
      ST_CPU: begin
        if (dma_req && (cpu_sync || at_max)) begin
          grant       = 1'b1;
          state_d     = ST_DMA;
          dma_gnt_d   = 1'b1;
          cpu_ready_d = 1'b0;
`ifdef MEMBUS_BURST_EN
          beat_d      = '0;
`endif
        end
      end
      ST_DMA: begin
        dma_rvalid_d = accept & ~dma_we;
`ifdef MEMBUS_BURST_EN
        if (accept)
          beat_d = beat_inc;
        if (!dma_req || (accept && beat_inc == BEAT_TOP)) begin
`else
        if (accept || !dma_req) begin
`endif
          state_d   = ST_RESTORE;
          dma_gnt_d = 1'b0;
        end
      end
      ST_RESTORE: begin
        state_d     = ST_CPU;
        cpu_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_CPU;
        cpu_ready_d = 1'b1;
        dma_gnt_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CPU;
      cpu_ready_q  <= 1'b1;
      dma_gnt_q    <= 1'b0;
      dma_rvalid_q <= 1'b0;
`ifdef MEMBUS_BURST_EN
      beat_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cpu_ready_q  <= cpu_ready_d;
      dma_gnt_q    <= dma_gnt_d;
      dma_rvalid_q <= dma_rvalid_d;
`ifdef MEMBUS_BURST_EN
      beat_q       <= beat_d;
`endif
    end
  end

  // RESTORE keeps the CPU address on the bus so memory re-primes
  // before the CPU resumes, but never writes.
  always_comb begin
    if (state_q == ST_DMA) begin
      mem_addr = dma_addr;
      mem_di   = dma_wdata;
      we_raw   = dma_we & dma_req & dma_gnt_q;
    end else begin
      mem_addr = cpu_addr_next;
      mem_di   = cpu_do_next;
      we_raw   = (state_q == ST_CPU) & cpu_we_next & cpu_ready_q;
    end
  end

  assign io_cs      = (mem_addr == IO_ADDR);
  assign mem_we     = we_raw & ~io_cs & ~reset;
  assign cpu_ready  = cpu_ready_q;
  assign cpu_di     = mem_do;
  assign dma_gnt    = dma_gnt_q;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = mem_do;

endmodule

// File: tb/tb_membus_arbiter.sv
// Randomised bench for membus_arbiter with a cycle-level reference model.
// Honours MEMBUS_BURST_EN the same way as the design.
module tb_membus_arbiter;

  localparam int          MAX_WAIT = 8;
  localparam logic [15:0] IO_A     = 16'hBFFC;
`ifdef MEMBUS_BURST_EN
  localparam int          BEATS    = 4;
`else
  localparam int          BEATS    = 1;
`endif
  localparam int O_CPU = 0;
  localparam int O_DMA = 1;
  localparam int O_RST = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr_next;
  logic        cpu_we_next;
  logic [7:0]  cpu_do_next;
  logic        cpu_sync;
  logic        cpu_ready;
  logic [7:0]  cpu_di;
  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_di;
  logic [7:0]  mem_do;
  logic        io_cs;

  membus_arbiter #(
    .MAX_WAIT (MAX_WAIT),
    .IO_ADDR  (IO_A)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_addr_next (cpu_addr_next),
    .cpu_we_next   (cpu_we_next),
    .cpu_do_next   (cpu_do_next),
    .cpu_sync      (cpu_sync),
    .cpu_ready     (cpu_ready),
    .cpu_di        (cpu_di),
    .dma_req       (dma_req),
    .dma_we        (dma_we),
    .dma_addr      (dma_addr),
    .dma_wdata     (dma_wdata),
    .dma_gnt       (dma_gnt),
    .dma_rvalid    (dma_rvalid),
    .dma_rdata     (dma_rdata),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_di        (mem_di),
    .mem_do        (mem_do),
    .io_cs         (io_cs)
  );

  always #5 clk = ~clk;

  // memory instance stand-in: synchronous, read-before-write
  logic [7:0] env_mem [0:65535];
  always @(posedge clk) begin
    if (mem_we)
      env_mem[mem_addr] <= mem_di;
    mem_do <= env_mem[mem_addr];
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [7:0] ref_mem [0:65535];
  bit         m_known = 0;
  int         m_owner, m_wait, m_beats;
  bit         m_ready, m_gnt, m_rvalid;
  logic [7:0] m_rdata, m_cpu_di;
  bit         m_di_ok = 0;

  bit         last_taken, last_gnt, seen_rvalid;
  logic [7:0] last_rdata;

  task automatic step();
    logic [15:0] ea;
    logic [7:0]  ed, n_rdata;
    bit          ew, eio, n_ready, n_gnt, n_rvalid;
    int          n_owner, n_wait, n_beats;
    #1;
    if (m_owner == O_DMA) begin
      ea = dma_addr;
      ed = dma_wdata;
      ew = dma_we && dma_req && m_gnt;
    end else begin
      ea = cpu_addr_next;
      ed = cpu_do_next;
      ew = (m_owner == O_CPU) && cpu_we_next && m_ready;
    end
    eio = (ea == IO_A);
    if (eio || reset)
      ew = 0;
    if (m_known) begin
      chk("cpu_ready", cpu_ready, m_ready);
      chk("dma_gnt", dma_gnt, m_gnt);
      chk("dma_rvalid", dma_rvalid, m_rvalid);
      if (m_rvalid)
        chk("dma_rdata", dma_rdata, m_rdata);
      chk("mem_addr", mem_addr, ea);
      chk("mem_we", mem_we, ew);
      if (ew)
        chk("mem_di", mem_di, ed);
      chk("io_cs", io_cs, eio);
    end
    if (m_di_ok)
      chk("cpu_di", cpu_di, m_cpu_di);
    last_gnt   = (dma_gnt === 1'b1);
    last_taken = last_gnt && dma_req && !reset;
    if (dma_rvalid === 1'b1) begin
      seen_rvalid = 1;
      last_rdata  = dma_rdata;
    end

    n_owner  = m_owner;
    n_ready  = m_ready;
    n_gnt    = m_gnt;
    n_rvalid = 0;
    n_rdata  = m_rdata;
    n_wait   = m_wait;
    n_beats  = m_beats;
    if (reset) begin
      n_owner = O_CPU;
      n_ready = 1;
      n_gnt   = 0;
      n_wait  = 0;
      n_beats = 0;
    end else if (m_owner == O_CPU) begin
      if (dma_req && (cpu_sync || m_wait == MAX_WAIT)) begin
        n_owner = O_DMA;
        n_gnt   = 1;
        n_ready = 0;
        n_wait  = 0;
        n_beats = 0;
      end else if (dma_req) begin
        n_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      end else begin
        n_wait = 0;
      end
    end else if (m_owner == O_DMA) begin
      if (dma_req) begin
        n_beats = m_beats + 1;
        if (!dma_we) begin
          n_rvalid = 1;
          n_rdata  = ref_mem[dma_addr];
        end
      end
      if (!dma_req || n_beats == BEATS) begin
        n_owner = O_RST;
        n_gnt   = 0;
      end
    end else begin
      n_owner = O_CPU;
      n_ready = 1;
      n_wait  = 0;
    end

    @(posedge clk);
    m_cpu_di = ref_mem[ea];
    m_di_ok  = 1;
    if (ew)
      ref_mem[ea] = ed;
    m_owner  = n_owner;
    m_ready  = n_ready;
    m_gnt    = n_gnt;
    m_rvalid = n_rvalid;
    m_rdata  = n_rdata;
    m_wait   = n_wait;
    m_beats  = n_beats;
    if (reset)
      m_known = 1;
    @(negedge clk);
  endtask

  task automatic dma_beat(input logic [15:0] a, input logic w,
                          input logic [7:0] d, input logic sync,
                          output int gnt_at);
    gnt_at     = -1;
    last_taken = 0;
    dma_addr   = a;
    dma_we     = w;
    dma_wdata  = d;
    dma_req    = 1;
    cpu_sync   = sync;
    for (int k = 0; k < 40; k++) begin
      step();
      if (last_gnt && gnt_at < 0)
        gnt_at = k;
      if (last_taken)
        break;
    end
    if (!last_taken)
      chk("dma_beat_timeout", 0, 1);
    dma_req  = 0;
    cpu_sync = 0;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 7))
      0:       return IO_A;
      1:       return 16'h1234;
      2:       return 16'h0200;
      default: return {8'h12, 8'($urandom)};
    endcase
  endfunction

  initial begin
    int   lat;
    bit   req_on;
    int   sync_pct;
    for (int i = 0; i < 65536; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    reset         = 1;
    cpu_addr_next = 16'h0000;
    cpu_we_next   = 0;
    cpu_do_next   = 8'h00;
    cpu_sync      = 0;
    dma_req       = 0;
    dma_we        = 0;
    dma_addr      = 16'h0000;
    dma_wdata     = 8'h00;
    @(negedge clk);
    step();
    step();
    reset = 0;
    chk("rst_ready", cpu_ready, 1);
    chk("rst_gnt", dma_gnt, 0);
    chk("rst_rvalid", dma_rvalid, 0);

    // CPU write loop, no DMA traffic
    for (int i = 0; i < 6; i++) begin
      cpu_addr_next = 16'h0200;
      cpu_we_next   = i[0];
      cpu_do_next   = 8'(i + 8'h30);
      cpu_sync      = (i % 3 == 0);
      step();
    end
    cpu_we_next = 0;
    cpu_sync    = 0;

    // synchronous grant, DMA write 0x5A to 0x1234
    dma_beat(16'h1234, 1'b1, 8'h5A, 1'b1, lat);
    chk("sync_gnt_lat", lat, 1);
    for (int i = 0; i < 3; i++) step();

    // forced grant with cpu_sync held low, DMA read of 0x1234
    seen_rvalid = 0;
    dma_beat(16'h1234, 1'b0, 8'h00, 1'b0, lat);
    chk("forced_gnt_lat", lat, MAX_WAIT + 1);
    for (int i = 0; i < 3; i++) step();
    chk("rd_seen", seen_rvalid, 1);
    chk("rd_1234", last_rdata, 8'h5A);

    // I/O port writes by both owners
    cpu_addr_next = IO_A;
    cpu_we_next   = 1;
    cpu_do_next   = 8'hEE;
    step();
    cpu_we_next   = 0;
    cpu_addr_next = 16'h0100;
    dma_beat(IO_A, 1'b1, 8'hDD, 1'b1, lat);
    for (int i = 0; i < 3; i++) step();

    // reset while the DMA owns the bus
    dma_addr  = 16'h3000;
    dma_we    = 1;
    dma_wdata = 8'h77;
    dma_req   = 1;
    cpu_sync  = 1;
    step();
    chk("pre_rst_gnt", dma_gnt, 1);
    reset = 1;
    step();
    reset   = 0;
    dma_req = 0;
    chk("midrst_gnt", dma_gnt, 0);
    chk("midrst_ready", cpu_ready, 1);
    chk("midrst_rvalid", dma_rvalid, 0);
    step();
    cpu_sync = 0;

`ifdef MEMBUS_BURST_EN
    // six-beat stream against a four-beat grant limit
    dma_addr = 16'h1240;
    dma_we   = 1;
    for (int b = 0; b < 6; b++) begin
      int k;
      dma_wdata = 8'(b + 8'hA0);
      dma_req   = 1;
      cpu_sync  = 1;
      for (k = 0; k < 40; k++) begin
        step();
        if (last_taken) break;
      end
      if (k == 40)
        chk("burst_timeout", 0, 1);
      dma_addr = dma_addr + 16'd1;
    end
    dma_req  = 0;
    cpu_sync = 0;
    for (int i = 0; i < 3; i++) step();
`endif

    // randomised traffic
    req_on   = 0;
    sync_pct = 25;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0)
        sync_pct = ($urandom_range(0, 2) == 0) ? 0 : 30;
      reset         = ($urandom_range(0, 299) == 0);
      cpu_addr_next = pick_addr();
      cpu_we_next   = $urandom_range(0, 2) == 0;
      cpu_do_next   = 8'($urandom);
      cpu_sync      = $urandom_range(0, 99) < sync_pct;
      if (!req_on && $urandom_range(0, 3) == 0) begin
        req_on    = 1;
        dma_addr  = pick_addr();
        dma_we    = $urandom_range(0, 1) == 1;
        dma_wdata = 8'($urandom);
      end
      dma_req = req_on;
      step();
      if (last_taken) begin
        req_on = ($urandom_range(0, 1) == 1);
        dma_addr  = dma_addr + 16'd1;
        dma_wdata = 8'($urandom);
        dma_we    = $urandom_range(0, 1) == 1;
      end
    end
    reset   = 0;
    dma_req = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
